// File: rtl/matmul_seq.sv
// matmul_seq: computes C = A x B for two N x N unsigned matrices held in a
// latency-modelled memory. One read is in flight at a time over the memory's
// init/busy handshake. Dot products are accumulated operand by operand, and
// each C element is streamed out row-major on a valid/ready port.
module matmul_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int N          = 4,
    parameter int A_BASE     = 0,
    parameter int B_BASE     = 16,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N),
    localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy_o,
    output logic                  done,
    output logic                  mem_init,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_busy,
    output logic                  c_valid,
    input  logic                  c_ready,
    output logic [ACC_WIDTH-1:0]  c_data,
    output logic [IW-1:0]         c_row,
    output logic [IW-1:0]         c_col
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_A,
        S_WAIT_A,
        S_REQ_B,
        S_WAIT_B,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t                  state;
    logic [IW-1:0]           i_reg;
    logic [IW-1:0]           j_reg;
    logic [IW-1:0]           k_reg;
    logic [ACC_WIDTH-1:0]    acc_reg;
    logic [DATA_WIDTH-1:0]   a_reg;
    logic                    busy_q;

    logic                    mem_fall;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    acc_sum;
    logic [IW-1:0]           k_inc;
    logic                    j_wrap;
    logic [IW-1:0]           j_next;
    logic [IW-1:0]           i_next;
    logic [ADDR_WIDTH-1:0]   addr_a_k_next;
    logic [ADDR_WIDTH-1:0]   addr_a_row_next;
    logic [ADDR_WIDTH-1:0]   addr_b;

    // Row-major word address; all arithmetic is done at ADDR_WIDTH so the
    // sum wraps modulo 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] addr_of(
        input int            base,
        input logic [IW-1:0] row,
        input logic [IW-1:0] col
    );
        return ADDR_WIDTH'(base) + ADDR_WIDTH'(row) * ADDR_WIDTH'(N) + ADDR_WIDTH'(col);
    endfunction

    // This block never writes the memory.
    assign mem_wr = 1'b0;

    // Index, address and accumulator arithmetic feeding the sequencer.
    always_comb begin
        // The memory has finished a read when busy drops after having been high.
        mem_fall        = busy_q && !mem_busy;
        // Full-width product: both operands zero-extended before multiplying.
        prod            = {{DATA_WIDTH{1'b0}}, a_reg} * {{DATA_WIDTH{1'b0}}, mem_rdata};
        acc_sum         = acc_reg + ACC_WIDTH'(prod);
        k_inc           = k_reg + 1'b1;
        j_wrap          = (j_reg == LAST);
        j_next          = j_wrap ? '0 : j_reg + 1'b1;
        i_next          = j_wrap ? i_reg + 1'b1 : i_reg;
        addr_a_k_next   = addr_of(A_BASE, i_reg, k_inc);
        addr_a_row_next = addr_of(A_BASE, i_next, '0);
        addr_b          = addr_of(B_BASE, k_reg, j_reg);
    end

    // Sequencer: issues reads, accumulates, emits C elements; all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            i_reg    <= '0;
            j_reg    <= '0;
            k_reg    <= '0;
            acc_reg  <= '0;
            a_reg    <= '0;
            busy_q   <= 1'b0;
            busy_o   <= 1'b0;
            done     <= 1'b0;
            mem_init <= 1'b0;
            mem_addr <= '0;
            c_valid  <= 1'b0;
            c_data   <= '0;
            c_row    <= '0;
            c_col    <= '0;
        end else begin
            // Single-cycle pulses default low.
            mem_init <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        i_reg    <= '0;
                        j_reg    <= '0;
                        k_reg    <= '0;
                        acc_reg  <= '0;
                        busy_o   <= 1'b1;
                        mem_init <= 1'b1;
                        mem_addr <= addr_of(A_BASE, '0, '0);
                        state    <= S_REQ_A;
                    end
                end
                S_REQ_A: begin
                    // Clearing here keeps a stale fall from the previous read
                    // from being seen in the coming wait.
                    busy_q <= 1'b0;
                    state  <= S_WAIT_A;
                end
                S_WAIT_A: begin
                    busy_q <= mem_busy;
                    if (mem_fall) begin
                        a_reg    <= mem_rdata;
                        mem_init <= 1'b1;
                        mem_addr <= addr_b;
                        state    <= S_REQ_B;
                    end
                end
                S_REQ_B: begin
                    busy_q <= 1'b0;
                    state  <= S_WAIT_B;
                end
                S_WAIT_B: begin
                    busy_q <= mem_busy;
                    if (mem_fall) begin
                        acc_reg <= acc_sum;
                        if (k_reg == LAST) begin
                            c_valid <= 1'b1;
                            c_data  <= acc_sum;
                            c_row   <= i_reg;
                            c_col   <= j_reg;
                            state   <= S_EMIT;
                        end else begin
                            k_reg    <= k_inc;
                            mem_init <= 1'b1;
                            mem_addr <= addr_a_k_next;
                            state    <= S_REQ_A;
                        end
                    end
                end
                S_EMIT: begin
                    // Outputs hold until the consumer takes the element.
                    if (c_ready) begin
                        c_valid <= 1'b0;
                        acc_reg <= '0;
                        k_reg   <= '0;
                        j_reg   <= j_next;
                        i_reg   <= i_next;
                        if (j_wrap && (i_reg == LAST)) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            mem_init <= 1'b1;
                            mem_addr <= addr_a_row_next;
                            state    <= S_REQ_A;
                        end
                    end
                end
                S_DONE: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
